stream_upsizer_arbiter: RTL and testbench
=========================================

# stream_upsizer_arbiter

Round-robin arbiter sharing one `stream_upsizer` between N narrow valid/ready sources. Grants a source for exactly SCALE accepted beats, one complete upsized word, so words never mix data from different sources. Sits directly in front of the upsizer's slave port. Exposes the granted source ID and a last-beat flag so downstream logic can tag each wide word.

## Interface
Parameters:
- `N`, 4: number of requesting sources, ≥2.
- `DW`, 8: narrow beat width in bits.
- `SCALE`, 4: beats per wide word, ≥1; must equal the downstream upsizer's SCALE.

Ports, where IW = max(1, $clog2(N)) and CW = max(1, $clog2(SCALE)):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data_i`  in  N*DW  source data; source k occupies bits [k*DW +: DW].
- `s_valid_i`  in  N  per-source valid.
- `s_ready_o`  out  N  per-source ready.
- `m_data_o`  out  DW  data from the granted source, to the upsizer's `s_data_i`.
- `m_valid_o`  out  1  valid to the upsizer.
- `m_ready_i`  in  1  ready from the upsizer.
- `m_id_o`  out  IW  index of the granted source; held for the whole word.
- `m_last_o`  out  1  high on beat SCALE-1 of the word.

## Operation
- State machine with two states, IDLE and LOCKED. Registers: `grant[IW]`, `last[IW]` (previous winner), `cnt[CW]`.
- IDLE:
  - If any `s_valid_i` bit is set, pick the first set bit scanning upward from `last+1`, wrapping modulo N.
  - Register the pick into `grant` and move to LOCKED.
  - If no bit is set, stay in IDLE.
- LOCKED:
  - `m_data_o` = slice `grant` of `s_data_i`.
  - `m_valid_o` = `s_valid_i[grant]`.
  - `s_ready_o[grant]` = `m_ready_i`; all other `s_ready_o` bits are 0.
  - A beat is accepted when `m_valid_o & m_ready_i`. Each accepted beat increments `cnt`.
  - On an accepted beat with `cnt == SCALE-1`: set `cnt` to 0, copy `grant` into `last`, return to IDLE.
- In IDLE, `m_valid_o`, `m_last_o` and every `s_ready_o` bit are 0. `m_data_o` is don't-care.
- `m_id_o` = `grant` in all states.
- `m_last_o` = LOCKED & (`cnt == SCALE-1`). With SCALE=1, every LOCKED beat is last.
- The granted source dropping valid mid-word only stalls the word. The grant is never revoked before SCALE beats.
- Requests from other sources during LOCKED are ignored until the next IDLE cycle.
- The ready path from `m_ready_i` to `s_ready_o` is combinational. No data is registered, so there is no buffering and no extra data latency.

## Timing
- Reset (asynchronous assert, synchronous deassert supplied externally):
  - State IDLE, `grant` = 0, `cnt` = 0, `last` = N-1, so source 0 has first priority.
  - Outputs during reset: `m_valid_o` = 0, `s_ready_o` = 0, `m_last_o` = 0, `m_id_o` = 0.
- Arbitration takes one cycle. A request seen in IDLE at edge t drives `m_valid_o` in cycle t+1.
- Word throughput is SCALE beats plus one IDLE bubble cycle, i.e. SCALE+1 cycles minimum per word.
- Reset mid-word: the partial word is abandoned and the counter is cleared. The upsizer must be reset from the same source; the integration rule is `rst = !rst_n`.
- With exactly one source continuously valid and `m_ready_i` = 1, that source is re-granted after every bubble.

## Structure
- Shared package `stream_utils_pkg`:
  - State encoding IDLE = 1'b0, LOCKED = 1'b1.
  - A `clog2_min1` helper function for IW and CW.
- Sub-module `stream_rr_pick`: combinational; takes the `req[N]` vector and `last[IW]`, produces `valid` and `idx[IW]`.
- The top level holds the FSM, the counter and the output muxing.

## Test plan
Defaults are N=4, DW=8, SCALE=4 unless stated.
- **Reset:** assert `rst_n` = 0 mid-cycle -> all outputs go to 0 immediately, without waiting for a clock edge; after release, the first grant goes to source 0 when all sources request.
- **Single source:** only source 2 valid, beats 0x11, 0x22, 0x33, 0x44, `m_ready_i` = 1 -> `m_id_o` = 2 on all four beats; `m_last_o` high only with 0x44; one bubble follows, then re-grant to source 2.
- **Round robin:** all four sources continuously valid -> grant order 0, 1, 2, 3, 0; each grant lasts exactly 4 accepted beats; no beat from another source appears within a word.
- **Backpressure and stall:** while locked to source 1, `m_ready_i` toggles every cycle and `s_valid_i[1]` drops for 3 cycles -> exactly 4 accepted beats; data order is preserved; no re-arbitration happens during the stall; the other sources' `s_ready_o` stay 0.
- **Reset mid-word:** reset asserted after 2 of 4 beats -> `cnt` = 0 and state is IDLE; the next word starts a fresh 4-beat count from source 0.
- **SCALE=1:** sources 0 and 3 valid -> grants alternate 0, 3, 0; `m_last_o` is high on every accepted beat; one bubble between grants.

Source files
------------

// File: rtl/stream_utils_pkg.sv
// rtl/stream_utils_pkg.sv - shared types and width helpers for the stream arbiter
package stream_utils_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/stream_upsizer_arbiter_if.sv
// rtl/stream_upsizer_arbiter_if.sv - narrow sources in, one granted stream out
interface stream_upsizer_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  import stream_utils_pkg::*;

  localparam int IW = clog2_min1(N);

  logic [N*DW-1:0] s_data_i;
  logic [N-1:0]    s_valid_i;
  logic [N-1:0]    s_ready_o;
  logic [DW-1:0]   m_data_o;
  logic            m_valid_o;
  logic            m_ready_i;
  logic [IW-1:0]   m_id_o;
  logic            m_last_o;

  // Environment side: drives sources and downstream ready.
  modport master (
    output s_data_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_valid_o, m_id_o, m_last_o
  );

  // Arbiter side.
  modport slave (
    input  s_data_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_valid_o, m_id_o, m_last_o
  );

endinterface

// File: rtl/stream_rr_pick.sv
// rtl/stream_rr_pick.sv - round-robin pick of the first request after the last winner
module stream_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so the source after the last winner sits at bit 0, then take the lowest set bit.
  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> (int'(last) + 1));
    valid = |rot;
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        idx = IW'((int'(last) + 1 + j) % N);
      end
    end
  end

endmodule

// File: rtl/stream_upsizer_arbiter.sv
// rtl/stream_upsizer_arbiter.sv - round-robin arbiter granting one source per upsized word
module stream_upsizer_arbiter
  import stream_utils_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int SCALE = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  stream_upsizer_arbiter_if.slave bus
);

  localparam int            IW       = clog2_min1(N);
  localparam int            CW       = clog2_min1(SCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCALE - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [IW-1:0] grant;
  logic [IW-1:0] last;
  logic [CW-1:0] cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          sel_valid;
  logic          beat_ok;
  logic          at_last;
  logic          word_end;

  stream_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (bus.s_valid_i),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sel_valid = bus.s_valid_i[grant];
  assign at_last   = (cnt == CNT_LAST);
  assign beat_ok   = (state == LOCKED) && sel_valid && bus.m_ready_i;
  assign word_end  = beat_ok && at_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: lock on any request, release only after the final beat of the word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = LOCKED;
      LOCKED:  if (word_end)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, previous winner and beat counter; reset gives source 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      last  <= IW'(N - 1);
      cnt   <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant <= pick_idx;
      end
      if (beat_ok) begin
        if (at_last) begin
          cnt  <= '0;
          last <= grant;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Outputs: only the granted source sees ready, and only while locked.
  always_comb begin
    bus.m_valid_o = 1'b0;
    bus.m_last_o  = 1'b0;
    bus.s_ready_o = '0;
    if (state == LOCKED) begin
      bus.m_valid_o        = sel_valid;
      bus.m_last_o         = at_last;
      bus.s_ready_o[grant] = bus.m_ready_i;
    end
  end

  assign bus.m_id_o   = grant;
  assign bus.m_data_o = bus.s_data_i[int'(grant) * DW +: DW];

endmodule

// File: tb/tb_stream_upsizer_arbiter.sv
// tb/tb_stream_upsizer_arbiter.sv - directed vector bench for stream_upsizer_arbiter
module tb_stream_upsizer_arbiter;
  import stream_utils_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stream_upsizer_arbiter_if #(.N(4), .DW(8)) ifa ();
  stream_upsizer_arbiter_if #(.N(4), .DW(8)) ifb ();

  stream_upsizer_arbiter #(.N(4), .DW(8), .SCALE(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  stream_upsizer_arbiter #(.N(4), .DW(8), .SCALE(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       rdy;
    logic       ev;
    logic [3:0] er;
    logic [1:0] eid;
    logic       el;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] v, input logic [7:0] d1, input logic [7:0] d2,
                              input logic rdy, input logic ev, input logic [3:0] er,
                              input logic [1:0] eid, input logic el, input logic [7:0] ed);
    tbl.push_back('{v, d1, d2, rdy, ev, er, eid, el, ed});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [1:0] rr_order [5];
  logic [1:0] s1_id    [3];

  initial begin
    total = 0;
    bad   = 0;

    // Single source 2: two back-to-back words with one bubble between.
    add(4'b0100, 8'h00, 8'h11, 1, 0, 4'b0000, 0, 0, 8'h00);
    add(4'b0100, 8'h00, 8'h11, 1, 1, 4'b0100, 2, 0, 8'h11);
    add(4'b0100, 8'h00, 8'h22, 1, 1, 4'b0100, 2, 0, 8'h22);
    add(4'b0100, 8'h00, 8'h33, 1, 1, 4'b0100, 2, 0, 8'h33);
    add(4'b0100, 8'h00, 8'h44, 1, 1, 4'b0100, 2, 1, 8'h44);
    add(4'b0100, 8'h00, 8'h55, 1, 0, 4'b0000, 2, 0, 8'h00);
    add(4'b0100, 8'h00, 8'h55, 1, 1, 4'b0100, 2, 0, 8'h55);
    add(4'b0100, 8'h00, 8'h66, 1, 1, 4'b0100, 2, 0, 8'h66);
    add(4'b0100, 8'h00, 8'h77, 1, 1, 4'b0100, 2, 0, 8'h77);
    add(4'b0100, 8'h00, 8'h88, 1, 1, 4'b0100, 2, 1, 8'h88);
    // Source 1 granted, then backpressure plus a 3-cycle valid drop with others requesting.
    add(4'b0010, 8'hA1, 8'h00, 1, 0, 4'b0000, 2, 0, 8'h00);
    add(4'b1111, 8'hA1, 8'hC0, 0, 1, 4'b0000, 1, 0, 8'hA1);
    add(4'b1111, 8'hA1, 8'hC0, 1, 1, 4'b0010, 1, 0, 8'hA1);
    add(4'b1101, 8'hA2, 8'hC0, 0, 0, 4'b0000, 1, 0, 8'h00);
    add(4'b1101, 8'hA2, 8'hC0, 1, 0, 4'b0010, 1, 0, 8'h00);
    add(4'b1101, 8'hA2, 8'hC0, 0, 0, 4'b0000, 1, 0, 8'h00);
    add(4'b1111, 8'hA2, 8'hC0, 1, 1, 4'b0010, 1, 0, 8'hA2);
    add(4'b1111, 8'hA3, 8'hC0, 0, 1, 4'b0000, 1, 0, 8'hA3);
    add(4'b1111, 8'hA3, 8'hC0, 1, 1, 4'b0010, 1, 0, 8'hA3);
    add(4'b1111, 8'hA4, 8'hC0, 0, 1, 4'b0000, 1, 1, 8'hA4);
    add(4'b1111, 8'hA4, 8'hC0, 1, 1, 4'b0010, 1, 1, 8'hA4);
    add(4'b1111, 8'hB1, 8'hC1, 1, 0, 4'b0000, 1, 0, 8'h00);
    add(4'b1111, 8'hB1, 8'hC1, 1, 1, 4'b0100, 2, 0, 8'hC1);

    rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    s1_id    = '{2'd0, 2'd3, 2'd0};

    ifb.s_valid_i = 4'b0000;
    ifb.s_data_i  = '0;
    ifb.m_ready_i = 1'b0;

    // Reset state with every source requesting.
    rst_n         = 1'b0;
    ifa.s_valid_i = 4'b1111;
    ifa.s_data_i  = 32'h0403_0201;
    ifa.m_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("reset m_valid", 32'(ifa.m_valid_o), 32'd0);
    chk("reset s_ready", 32'(ifa.s_ready_o), 32'd0);
    chk("reset m_last",  32'(ifa.m_last_o),  32'd0);
    chk("reset m_id",    32'(ifa.m_id_o),    32'd0);
    @(negedge clk);
    ifa.s_valid_i = 4'b0000;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      ifa.s_valid_i = tbl[i].v;
      ifa.s_data_i  = {8'hE3, tbl[i].d2, tbl[i].d1, 8'hE0};
      ifa.m_ready_i = tbl[i].rdy;
      #2;
      chk($sformatf("row%0d m_valid", i), 32'(ifa.m_valid_o), 32'(tbl[i].ev));
      chk($sformatf("row%0d s_ready", i), 32'(ifa.s_ready_o), 32'(tbl[i].er));
      chk($sformatf("row%0d m_id", i),    32'(ifa.m_id_o),    32'(tbl[i].eid));
      chk($sformatf("row%0d m_last", i),  32'(ifa.m_last_o),  32'(tbl[i].el));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d m_data", i), 32'(ifa.m_data_o), 32'(tbl[i].ed));
      end
    end

    // Second beat of the source-2 word, then reset with two beats accepted.
    @(posedge clk);
    #1;
    ifa.s_data_i = {8'hE3, 8'hC2, 8'hB1, 8'hE0};
    #2;
    chk("midword beat2 data", 32'(ifa.m_data_o), 32'hC2);
    @(posedge clk);
    #1;
    chk("midword pre-reset valid", 32'(ifa.m_valid_o), 32'd1);
    chk("midword pre-reset cnt",   32'(dut_a.cnt),     32'd2);
    rst_n = 1'b0;
    #1;
    chk("async reset m_valid", 32'(ifa.m_valid_o), 32'd0);
    chk("async reset s_ready", 32'(ifa.s_ready_o), 32'd0);
    chk("async reset m_last",  32'(ifa.m_last_o),  32'd0);
    chk("async reset m_id",    32'(ifa.m_id_o),    32'd0);
    chk("async reset cnt",     32'(dut_a.cnt),     32'd0);
    chk("async reset state",   32'(dut_a.state),   32'(IDLE));
    @(negedge clk);
    ifa.s_valid_i = 4'b1111;
    ifa.s_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ifa.m_ready_i = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post-reset idle", 32'(ifa.m_valid_o), 32'd0);

    // Round robin with all sources valid: fresh count from source 0.
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        @(posedge clk);
        #3;
        chk($sformatf("rr w%0d b%0d valid", w, b), 32'(ifa.m_valid_o), 32'd1);
        chk($sformatf("rr w%0d b%0d id", w, b),    32'(ifa.m_id_o),    32'(rr_order[w]));
        chk($sformatf("rr w%0d b%0d data", w, b),  32'(ifa.m_data_o),  32'(8'hA0 + 8'(rr_order[w])));
        chk($sformatf("rr w%0d b%0d last", w, b),  32'(ifa.m_last_o),  32'(b == 3));
      end
      @(posedge clk);
      #3;
      chk($sformatf("rr w%0d bubble", w), 32'(ifa.m_valid_o), 32'd0);
    end
    ifa.s_valid_i = 4'b0000;

    // SCALE=1: sources 0 and 3 alternate with one bubble between grants.
    @(posedge clk);
    #1;
    ifb.s_valid_i = 4'b1001;
    ifb.s_data_i  = {8'h13, 8'h00, 8'h00, 8'h10};
    ifb.m_ready_i = 1'b1;
    #2;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #3;
      end
      chk($sformatf("s1 c%0d valid", c), 32'(ifb.m_valid_o), 32'(c % 2));
      chk($sformatf("s1 c%0d last", c),  32'(ifb.m_last_o),  32'(c % 2));
      if (c % 2 == 1) begin
        chk($sformatf("s1 c%0d id", c),   32'(ifb.m_id_o),   32'(s1_id[c / 2]));
        chk($sformatf("s1 c%0d data", c), 32'(ifb.m_data_o), 32'(8'h10 + 8'(s1_id[c / 2])));
        chk($sformatf("s1 c%0d ready", c), 32'(ifb.s_ready_o), 32'(4'b0001 << s1_id[c / 2]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
